// File: rtl/uart_mem_bridge.sv
// Tunnels the picorv32 native memory bus over a UART byte stream to a host that serves all accesses.
// Define UART_MEM_BRIDGE_TIMEOUT_EN to bound the wait for a host response.
module uart_mem_bridge #(
    parameter logic [7:0]  AckByte       = 8'hA5,
    parameter logic [23:0] TimeoutCycles = 24'd1200000,
    parameter logic [31:0] TimeoutData   = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_valid_i,
    input  logic        mem_instr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StSendCmd,
        StSendAddr,
        StSendData,
        StRecvData,
        StRecvAck,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;

    logic        is_write;
    logic        in_recv;
    logic        rx_fire;
    logic        timeout;
    logic [7:0]  cmd_byte;

    assign is_write = |wstrb_q;
    assign cmd_byte = {2'b00, instr_q, is_write, wstrb_q};
    assign in_recv  = (state_q == StRecvData) || (state_q == StRecvAck);
    // Built from state rather than rx_ready_o to keep the timeout path free of comb loops.
    assign rx_fire  = rx_valid_i & in_recv;
    assign busy_o   = (state_q != StIdle);

`ifdef UART_MEM_BRIDGE_TIMEOUT_EN
    logic [23:0] cnt_q, cnt_d;

    // Held at zero outside RECV_* so it is clear on entry; restarts on every accepted byte.
    always_comb begin
        cnt_d = '0;
        if (in_recv && !rx_fire) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    assign timeout = in_recv && !rx_fire && (cnt_q == TimeoutCycles - 24'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^{TimeoutCycles, TimeoutData};
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        rx_ready_o  = 1'b0;
        mem_ready_o = 1'b0;
        mem_rdata_o = 32'h0;
        err_o       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_valid_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    wstrb_d = mem_wstrb_i;
                    instr_d = mem_instr_i;
                    rdata_d = 32'h0;
                    idx_d   = 2'd0;
                    state_d = StSendCmd;
                end
            end
            StSendCmd: begin
                tx_valid_o = 1'b1;
                tx_data_o  = cmd_byte;
                if (tx_ready_i) begin
                    state_d = StSendAddr;
                end
            end
            StSendAddr: begin
                tx_valid_o = 1'b1;
                tx_data_o  = addr_q[8*idx_q +: 8];
                if (tx_ready_i) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = is_write ? StSendData : StRecvData;
                    end
                end
            end
            StSendData: begin
                tx_valid_o = 1'b1;
                tx_data_o  = wdata_q[8*idx_q +: 8];
                if (tx_ready_i) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StRecvAck;
                    end
                end
            end
            StRecvData: begin
                rx_ready_o = 1'b1;
                if (rx_fire) begin
                    rdata_d[8*idx_q +: 8] = rx_data_i;
                    idx_d                 = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StDone;
                    end
                end else if (timeout) begin
                    rdata_d = TimeoutData;
                    err_o   = 1'b1;
                    state_d = StDone;
                end
            end
            StRecvAck: begin
                rx_ready_o = 1'b1;
                if (rx_fire) begin
                    err_o   = (rx_data_i != AckByte);
                    state_d = StDone;
                end else if (timeout) begin
                    err_o   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                mem_ready_o = 1'b1;
                mem_rdata_o = rdata_q;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            instr_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge: table vectors plus random transactions against a frame-level host model.
`timescale 1ns/1ps
module tb_uart_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        err;

    uart_mem_bridge #(
        .AckByte      (8'hA5),
        .TimeoutCycles(24'd100),
        .TimeoutData  (32'hDEADBEEF)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .mem_valid_i(mem_valid),
        .mem_instr_i(mem_instr),
        .mem_addr_i (mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_wstrb_i(mem_wstrb),
        .mem_ready_o(mem_ready),
        .mem_rdata_o(mem_rdata),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .busy_o     (busy),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic [31:0] resp;      // read data LSB first, or ack byte in [7:0]
        int          stall;     // 0: tx always ready, 1: 3 stall cycles per byte, 2: random
        bit          early_rx;  // host pushes its first byte before the request frame ends
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic [7:0] exp_tx[$];

    // Drives one CPU access and plays the host; entered and left at posedge+1.
    task automatic run_txn(input vec_t v);
        logic [7:0] rx_bytes[4];
        int         rx_len;
        int         rx_idx;
        int         stall_cnt;
        bit         done;
        bit         wr;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       exp_rxr;
        logic       exp_rdy;

        wr = (v.wstrb != 4'h0);
        exp_tx.delete();
        exp_tx.push_back({2'b00, v.instr, wr, v.wstrb});
        for (int i = 0; i < 4; i++) exp_tx.push_back(v.addr[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) exp_tx.push_back(v.wdata[8*i +: 8]);
        for (int i = 0; i < 4; i++) rx_bytes[i] = v.resp[8*i +: 8];
        rx_len = wr ? 1 : 4;

        mem_valid = 1'b1;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        mem_instr = v.instr;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        @(posedge clk);
        #1;
        // Request is latched; scrambling the bus must not disturb the frame.
        mem_valid = 1'b0;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom_range(0, 15));
        mem_instr = 1'($urandom_range(0, 1));

        done       = 1'b0;
        rx_idx     = 0;
        stall_cnt  = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            case (v.stall)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (stall_cnt >= 3);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            rx_valid = (rx_idx < rx_len) && (v.early_rx || exp_tx.size() == 0) &&
                       (v.stall < 2 || $urandom_range(0, 2) != 0);
            rx_data  = (rx_idx < rx_len) ? rx_bytes[rx_idx] : 8'($urandom_range(0, 255));
            #4;
            exp_rxr = (exp_tx.size() == 0) && (rx_idx < rx_len);
            exp_rdy = (exp_tx.size() == 0) && (rx_idx == rx_len);
            chk("tx_valid", 32'(tx_valid), 32'(exp_tx.size() != 0));
            chk("rx_ready", 32'(rx_ready), 32'(exp_rxr));
            chk("mem_ready", 32'(mem_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'd1);
            chk("err", 32'(err), 32'((wr && rx_valid && exp_rxr) ? v.exp_err : 1'b0));
            chk("mem_rdata", mem_rdata, exp_rdy ? v.exp_rdata : 32'h0);
            if (prev_stall) chk("tx_stable", 32'(tx_data), 32'(prev_data));
            if (exp_tx.size() != 0) begin
                if (tx_valid && tx_ready) begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                    stall_cnt = 0;
                end else begin
                    stall_cnt++;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (rx_valid && exp_rxr) rx_idx++;
            if (exp_rdy) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        #4;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_ready", 32'(mem_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {19'h0, tx_data, tx_valid, rx_ready, mem_ready, busy, err}, 32'h0);
        chk(name, mem_rdata, 32'h0);
    endtask

    vec_t vecs[5];
    vec_t rv;

    initial begin
        vecs[0] = '{32'h0000_0010, 32'h0, 4'h0, 1'b1, 32'h0000_0513, 0, 1'b0, 32'h0000_0513, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'hCAFEBABE, 4'b0011, 1'b0, 32'h0000_00A5, 1, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{32'h0000_0100, 32'hCAFEBABE, 4'b0011, 1'b0, 32'h0000_005A, 1, 1'b0, 32'h0, 1'b1};
        vecs[3] = '{32'h1234_5678, 32'h0, 4'h0, 1'b0, 32'h1122_33FF, 0, 1'b1, 32'h1122_33FF, 1'b0};
        vecs[4] = '{32'h8000_0004, 32'h0102_0304, 4'hF, 1'b0, 32'h0000_00A5, 2, 1'b1, 32'h0, 1'b0};

        rst_n     = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        #2;
        chk_all_zero("reset_outs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Reset after the cmd byte and addr[7:0] have gone out.
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0010;
        mem_wstrb = 4'h0;
        mem_instr = 1'b1;
        tx_ready  = 1'b1;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midframe_reset");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        tx_ready = 1'b0;
        #3;
        chk("post_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        run_txn(vecs[0]);

        for (int n = 0; n < 20; n++) begin
            rv.addr     = $urandom;
            rv.wdata    = $urandom;
            rv.wstrb    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rv.instr    = 1'($urandom_range(0, 1));
            rv.resp     = $urandom;
            if (rv.wstrb != 4'h0 && $urandom_range(0, 3) != 0) rv.resp[7:0] = 8'hA5;
            rv.stall    = int'($urandom_range(0, 2));
            rv.early_rx = 1'($urandom_range(0, 1));
            rv.exp_rdata = (rv.wstrb == 4'h0) ? rv.resp : 32'h0;
            rv.exp_err   = (rv.wstrb != 4'h0) && (rv.resp[7:0] != 8'hA5);
            run_txn(rv);
        end

`ifdef UART_MEM_BRIDGE_TIMEOUT_EN
        begin
            int entry;
            int rdy_at;
            int err_at;
            entry  = -1;
            rdy_at = -1;
            err_at = -1;
            mem_valid = 1'b1;
            mem_addr  = 32'h0000_0040;
            mem_wstrb = 4'h0;
            mem_instr = 1'b0;
            tx_ready  = 1'b1;
            rx_valid  = 1'b0;
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            for (int c = 0; c < 500 && rdy_at < 0; c++) begin
                #4;
                if (rx_ready && entry < 0) entry = c;
                if (err) err_at = c;
                if (mem_ready) begin
                    rdy_at = c;
                    chk("to_rdata", mem_rdata, 32'hDEADBEEF);
                end
                @(posedge clk);
                #1;
            end
            chk("to_seen", 32'(rdy_at >= 0), 32'd1);
            chk("to_delay", 32'(rdy_at - entry), 32'd100);
            chk("to_err", 32'(err_at), 32'(rdy_at - 1));
            #4;
            chk("to_idle", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
Bridges the picorv32 native memory interface to a byte stream so a host on the far end of the UART serves all CPU memory traffic. Sits inside the icesugar top between the CPU and the UART rx/tx byte cores. Each CPU access becomes a request frame out on tx. The bridge then waits for a response frame on rx and completes the access with a single mem_ready pulse.

Parameters:
AckByte, 8'hA5, expected write-acknowledge byte from host
TimeoutCycles, 24'd1200000, response timeout in clk_i cycles (100 ms at 12 MHz); used only with the optional feature
TimeoutData, 32'hDEADBEEF, rdata returned on read timeout

Ports:
clk_i  input  1  system clock (12 MHz)
rst_ni  input  1  asynchronous active-low reset
mem_valid_i  input  1  CPU request valid
mem_instr_i  input  1  request is an instruction fetch
mem_addr_i  input  32  byte address
mem_wdata_i  input  32  write data
mem_wstrb_i  input  4  byte write strobes; 0 = read
mem_ready_o  output  1  one-cycle completion pulse
mem_rdata_o  output  32  read data, valid while mem_ready_o=1
tx_data_o  output  8  byte to UART transmitter
tx_valid_o  output  1  tx byte valid
tx_ready_i  input  1  transmitter accepts byte
rx_data_i  input  8  byte from UART receiver
rx_valid_i  input  1  rx byte valid
rx_ready_o  output  1  bridge accepts rx byte
busy_o  output  1  transaction in progress (state != IDLE)
err_o  output  1  one-cycle pulse on bad ack or timeout

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; request latches 0.
- Byte handshakes: a byte transfers on a cycle where valid and ready are both 1. tx_data_o is held stable while tx_valid_o=1 and tx_ready_i=0.
- Command byte: cmd = {2'b00, instr, write, wstrb[3:0]}, where write = |mem_wstrb_i.
- Request frame: cmd, then addr[7:0], addr[15:8], addr[23:16], addr[31:24]. Writes append wdata bytes, least-significant byte first.
- Response frame: a read returns 4 rx bytes, LSB first. A write returns 1 ack byte.
- FSM transitions:
  - IDLE: when mem_valid_i=1, latch addr, wdata, wstrb and instr, then go to SEND_CMD.
  - SEND_CMD: after the cmd byte transfers, go to SEND_ADDR.
  - SEND_ADDR: 2-bit byte index; after byte 3 transfers, go to SEND_DATA if write, else RECV_DATA.
  - SEND_DATA: after 4 bytes, go to RECV_ACK.
  - RECV_DATA: rx_ready_o=1. Each accepted byte shifts into rdata at byte index. After byte 3, go to DONE.
  - RECV_ACK: rx_ready_o=1. After 1 byte, go to DONE. If the byte != AckByte, pulse err_o in the same cycle the byte is accepted; the access still completes.
  - DONE: mem_ready_o=1 for exactly one cycle with mem_rdata_o valid, then IDLE. mem_rdata_o is 0 for writes.
- Minimum latency: a read with tx/rx always ready has 5 tx cycles + 4 rx cycles + 1 DONE cycle from the cycle after acceptance.
- rx_ready_o is 0 outside RECV_*. Unsolicited host bytes are back-pressured, never dropped.
- mem_valid_i is sampled only in IDLE. Changes to mem_* mid-transaction are ignored because the request is latched.
- The IDLE cycle after DONE is mandatory. Back-to-back requests therefore start no sooner than 2 cycles after mem_ready_o.
- Reset mid-frame: immediate return to IDLE, outputs cleared, partial frame abandoned. The host is responsible for resync.

Optional Feature:
Macro UART_MEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to RECV_* and on every accepted rx byte, and increments each cycle in RECV_*.
  - Reaching TimeoutCycles forces DONE with err_o pulsed.
  - mem_rdata_o = TimeoutData for reads, 0 for writes.
- Undefined: no counter; the bridge waits indefinitely in RECV_*.

Test Plan:
1. Read, tx/rx always ready. CPU read addr 0x00000010, wstrb 0, instr 1. Expected tx bytes: 20 10 00 00 00. Host answers 13 05 00 00. Expected: mem_ready_o single pulse, mem_rdata_o=0x00000513, err_o=0.
2. Write with partial strobe and tx backpressure. Write addr 0x00000100, wdata 0xCAFEBABE, wstrb 4'b0011. Stall tx_ready_i low 3 cycles per byte. Expected tx bytes: 13 00 01 00 00 BE BA FE CA, with tx_data_o stable during stalls. Host ack A5 -> mem_ready_o pulse, err_o=0.
3. Bad ack. Same write, host acks 0x5A -> err_o pulse coincident with the byte accept, then mem_ready_o pulse on the next cycle.
4. Unsolicited rx. Host drives rx_valid_i=1 with 0xFF during SEND_ADDR -> rx_ready_o=0 and no rdata change. The byte is consumed as byte 0 once RECV_DATA is entered.
5. Reset mid-frame. Assert rst_ni=0 after 2 tx bytes of a read -> all outputs 0 asynchronously. After release, busy_o=0 and a new read completes normally.
6. Timeout (UART_MEM_BRIDGE_TIMEOUT_EN, TimeoutCycles=100). Read with no host reply -> mem_ready_o pulse 100 cycles after RECV_DATA entry, mem_rdata_o=0xDEADBEEF, err_o pulse.
